// File: rtl/uart_program_loader.sv
// Serial program loader: receives RAM_LENGTH bytes over 8N1 UART, writes them to RAM
// from address 0 upward and holds the CPU in clear for the duration of the session.
module uart_program_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_LENGTH    = 16,
    parameter int CLKS_PER_BIT  = 104
) (
    input  logic                     i_SYS_CLOCK,
    input  logic                     i_CLEAR,
    input  logic                     i_UART_RX,
    input  logic                     i_LOAD_START,
    output logic [ADDRESS_WIDTH-1:0] o_RAM_ADDRESS,
    output logic [DATA_WIDTH-1:0]    o_RAM_DATA,
    output logic                     o_RAM_WRITE,
    output logic                     o_CPU_HOLD,
    output logic                     o_BUSY,
    output logic                     o_DONE,
    output logic                     o_FRAME_ERROR,
    output logic [ADDRESS_WIDTH:0]   o_BYTE_COUNT
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);
    localparam int COUNT_W = ADDRESS_WIDTH + 1;

    localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(RAM_LENGTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {L_IDLE, L_LOAD} load_state_t;

    rx_state_t   rx_state, rx_state_next;
    load_state_t load_state, load_state_next;

    logic                  rx_meta, rx_s;
    logic [TIMER_W-1:0]    timer;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  byte_valid, frame_err, wait_high;
    logic                  half_hit, full_hit;
    logic                  bit_sample, shift_en, stop_good, stop_bad;

    logic [COUNT_W-1:0]       count;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_data;
    logic                     ram_write, done, frame_error;
    logic                     write_en, set_frame_error, done_set;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_UART_RX;
            rx_s    <= rx_meta;
        end
    end

    assign half_hit = (timer == HALF_LAST);
    assign full_hit = (timer == FULL_LAST);

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s && !wait_high) rx_state_next = RX_START;
            RX_START: if (half_hit) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == LAST_BIT) rx_state_next = RX_STOP;
            RX_STOP:  if (full_hit) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        bit_sample = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state)
            RX_START: bit_sample = half_hit;
            RX_DATA: begin
                bit_sample = full_hit;
                shift_en   = full_hit;
            end
            RX_STOP: begin
                bit_sample = full_hit;
                stop_good  = full_hit && rx_s;
                stop_bad   = full_hit && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) begin
            timer      <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            wait_high  <= 1'b0;
        end else begin
            byte_valid <= stop_good;
            frame_err  <= stop_bad;
            if (rx_state == RX_IDLE || bit_sample) timer <= '0;
            else                                   timer <= timer + TIMER_W'(1);
            if (rx_state == RX_START) bit_idx <= '0;
            else if (shift_en)        bit_idx <= bit_idx + BIT_W'(1);
            if (shift_en) rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
            // A bad stop bit leaves the line low; only a return to idle-high may re-arm.
            if (stop_bad)                           wait_high <= 1'b1;
            else if (rx_state == RX_IDLE && rx_s)   wait_high <= 1'b0;
        end
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) load_state <= L_IDLE;
        else         load_state <= load_state_next;
    end

    always_comb begin
        load_state_next = load_state;
        case (load_state)
            L_IDLE: if (i_LOAD_START) load_state_next = L_LOAD;
            L_LOAD: if (!i_LOAD_START && count == LAST_COUNT) load_state_next = L_IDLE;
            default: load_state_next = L_IDLE;
        endcase
    end

    // A load request restarts the session and outranks a byte arriving in the same cycle.
    always_comb begin
        o_CPU_HOLD      = (load_state == L_LOAD);
        o_BUSY          = (load_state == L_LOAD);
        write_en        = (load_state == L_LOAD) && byte_valid && !i_LOAD_START
                          && count != LAST_COUNT;
        set_frame_error = (load_state == L_LOAD) && frame_err && !i_LOAD_START;
        done_set        = (load_state == L_LOAD) && !i_LOAD_START && count == LAST_COUNT;
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) begin
            count       <= '0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_write   <= 1'b0;
            done        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            ram_write <= write_en;
            done      <= done_set;
            if (write_en) begin
                ram_addr <= count[ADDRESS_WIDTH-1:0];
                ram_data <= rx_shift;
            end
            if (i_LOAD_START)  count <= '0;
            else if (write_en) count <= count + COUNT_W'(1);
            if (i_LOAD_START)         frame_error <= 1'b0;
            else if (set_frame_error) frame_error <= 1'b1;
        end
    end

    assign o_RAM_ADDRESS = ram_addr;
    assign o_RAM_DATA    = ram_data;
    assign o_RAM_WRITE   = ram_write;
    assign o_DONE        = done;
    assign o_FRAME_ERROR = frame_error;
    assign o_BYTE_COUNT  = count;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: drives 8N1 frames at 8 clocks per bit and
// scoreboards RAM strobes, done pulses and status outputs against hand-computed values.
module tb_uart_program_loader;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       rx = 1'b1;
    logic       load_start = 1'b0;
    logic [3:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_write, cpu_hold, busy, done, frame_error;
    logic [4:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_program_loader #(
        .DATA_WIDTH   (8),
        .ADDRESS_WIDTH(4),
        .RAM_LENGTH   (16),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_SYS_CLOCK  (clk),
        .i_CLEAR      (clear),
        .i_UART_RX    (rx),
        .i_LOAD_START (load_start),
        .o_RAM_ADDRESS(ram_address),
        .o_RAM_DATA   (ram_data),
        .o_RAM_WRITE  (ram_write),
        .o_CPU_HOLD   (cpu_hold),
        .o_BUSY       (busy),
        .o_DONE       (done),
        .o_FRAME_ERROR(frame_error),
        .o_BYTE_COUNT (byte_count)
    );

    always #5 clk = ~clk;

    // Observed write strobes and done pulses, sampled on the falling edge.
    int         wa[$];
    int         wd[$];
    int         cyc = 0;
    int         last_wr_cyc = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         hold_hi_cnt = 0;
    logic       done_hold = 1'b1;
    logic       hold_before_done = 1'b0;
    logic       prev_hold = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ram_write === 1'b1) begin
            wa.push_back(int'(ram_address));
            wd.push_back(int'(ram_data));
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt         = done_cnt + 1;
            done_cyc         = cyc;
            done_hold        = cpu_hold;
            hold_before_done = prev_hold;
        end
        if (cpu_hold === 1'b1) hold_hi_cnt = hold_hi_cnt + 1;
        prev_hold = cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Start and data bits only; the caller drives the stop bit.
    task automatic send_head(input logic [7:0] d);
        rx = 1'b0;
        wait_ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_head(d);
        rx = stop_bit;
        wait_ticks(CPB);
    endtask

    task automatic check_writes(input string tag, input int base, input int n,
                                input int first_data);
        check({tag, "_nwrites"}, wa.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wa.size()) begin
                check($sformatf("%s_addr[%0d]", tag, i), wa[base+i], i);
                check($sformatf("%s_data[%0d]", tag, i), wd[base+i], first_data + i);
            end
        end
    endtask

    task automatic check_done(input string tag, input int done_base);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_done_after_last_write"}, done_cyc - last_wr_cyc, 1);
        check({tag, "_hold_low_with_done"}, done_hold, 1'b0);
        check({tag, "_hold_high_before_done"}, hold_before_done, 1'b1);
        check({tag, "_hold_after"}, cpu_hold, 1'b0);
        check({tag, "_byte_count"}, byte_count, 16);
    endtask

    task automatic full_load(input string tag, input int first_data);
        int base;
        int dbase;
        base  = wa.size();
        dbase = done_cnt;
        pulse_start();
        check({tag, "_hold_on_start"}, cpu_hold, 1'b1);
        check({tag, "_busy_on_start"}, busy, 1'b1);
        check({tag, "_count_on_start"}, byte_count, 0);
        for (int i = 0; i < 16; i++) send_frame(8'(first_data + i), 1'b1);
        wait_ticks(20);
        check_writes(tag, base, 16, first_data);
        check_done(tag, dbase);
    endtask

    initial begin
        int base;
        int dbase;
        int hbase;

        // Reset with the line toggling.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        tick();
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_write", ram_write, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_count", byte_count, 0);
        clear = 1'b0;
        wait_ticks(4);
        check("rst_no_writes", wa.size(), 0);

        // Full load of 0xA0..0xAF, back-to-back frames.
        full_load("load1", 8'hA0);

        // Idle traffic: a frame while not loading is ignored.
        base  = wa.size();
        hbase = hold_hi_cnt;
        send_frame(8'h77, 1'b1);
        wait_ticks(20);
        check("idle_no_write", wa.size() - base, 0);
        check("idle_hold_never_high", hold_hi_cnt - hbase, 0);

        // Glitch, good byte, bad stop bit, good byte.
        base = wa.size();
        pulse_start();
        rx = 1'b0;
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(2 * CPB);
        check("glitch_no_write", wa.size() - base, 0);
        check("glitch_count", byte_count, 0);
        send_frame(8'h11, 1'b1);
        wait_ticks(4);
        check("ferr_before", frame_error, 0);
        send_frame(8'h55, 1'b0);
        rx = 1'b1;
        wait_ticks(CPB);
        check("ferr_set", frame_error, 1);
        check("ferr_count_unchanged", byte_count, 1);
        send_frame(8'h3C, 1'b1);
        wait_ticks(4);
        check("ferr_nwrites", wa.size() - base, 2);
        if (wa.size() - base == 2) begin
            check("ferr_addr0", wa[base], 0);
            check("ferr_data0", wd[base], 8'h11);
            check("ferr_addr1", wa[base+1], 1);
            check("ferr_data1", wd[base+1], 8'h3C);
        end
        check("ferr_count", byte_count, 2);
        check("ferr_sticky", frame_error, 1);
        check("ferr_hold", cpu_hold, 1);

        // Restart: clears error and count, then 5 bytes, restart again, 16 bytes.
        dbase = done_cnt;
        pulse_start();
        check("rs_ferr_cleared", frame_error, 0);
        check("rs_count_cleared", byte_count, 0);
        base = wa.size();
        for (int i = 0; i < 5; i++) send_frame(8'(i), 1'b1);
        wait_ticks(4);
        check_writes("rs_pre", base, 5, 0);
        check("rs_pre_count", byte_count, 5);
        pulse_start();
        check("rs_count_zero", byte_count, 0);
        check("rs_hold", cpu_hold, 1);
        base = wa.size();
        for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 1'b1);
        wait_ticks(20);
        check_writes("rs_post", base, 16, 8'h10);
        check_done("rs", dbase);

        // Clear during the stop bit of the fourth byte of a session.
        base = wa.size();
        pulse_start();
        for (int i = 0; i < 3; i++) send_frame(8'(8'h60 + i), 1'b1);
        send_head(8'h63);
        rx = 1'b1;
        wait_ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_hold", cpu_hold, 0);
        check("clr_busy", busy, 0);
        check("clr_count", byte_count, 0);
        check("clr_addr", ram_address, 0);
        check("clr_data", ram_data, 0);
        wait_ticks(CPB + 10);
        check_writes("clr_pre", base, 3, 8'h60);
        check("clr_write_low", ram_write, 0);

        // A fresh full load after the clear.
        full_load("load2", 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run length.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
